myfifo_write_arbiter: RTL and testbench

//  Round-robin arbiter that shares one myfifo write port among C_NUM_REQ requesters.

---
 rtl/myfifo_write_arbiter_if.sv | 40 ++++
 rtl/myfifo_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_myfifo_write_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/myfifo_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// myfifo_write_arbiter_if
// Purpose : bundles the requester streams and the shared FIFO write port that
//           the round-robin write arbiter sits between.
// Modports:
//   master - environment side: drives requests, FIFO ready and FIFO size,
//            observes ready/valid/data coming back from the arbiter.
//   slave  - arbiter side: the reverse directions.
// Signals :
//   req_valid/req_ready/req_last [C_NUM_REQ]   per-requester handshake
//   req_data [C_NUM_REQ*C_DATA_WIDTH]          requester i at [i*W +: W]
//   fifo_write_valid/ready, fifo_write_data    FIFO write port
//   fifo_size [$clog2(C_FIFO_DEPTH)+1]         FIFO occupancy
// ---------------------------------------------------------------------------
interface myfifo_write_arbiter_if #(
  parameter int C_NUM_REQ    = 4,
  parameter int C_DATA_WIDTH = 64,
  parameter int C_FIFO_DEPTH = 10
);
  localparam int SIZE_W = $clog2(C_FIFO_DEPTH) + 1;

  logic [C_NUM_REQ-1:0]              req_valid;
  logic [C_NUM_REQ-1:0]              req_ready;
  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_data;
  logic [C_NUM_REQ-1:0]              req_last;
  logic                              fifo_write_valid;
  logic                              fifo_write_ready;
  logic [C_DATA_WIDTH-1:0]           fifo_write_data;
  logic [SIZE_W-1:0]                 fifo_size;

  modport master (
    output req_valid, req_data, req_last, fifo_write_ready, fifo_size,
    input  req_ready, fifo_write_valid, fifo_write_data
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_write_ready, fifo_size,
    output req_ready, fifo_write_valid, fifo_write_data
  );
endinterface

// File: rtl/myfifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// myfifo_write_arbiter
// Purpose : round-robin arbiter sharing one myfifo write port among C_NUM_REQ
//           requesters. A grant is held for a burst that ends on a committed
//           last beat or after C_MAX_BURST committed beats. One arbitration
//           (idle) cycle separates consecutive grants.
// Ports   :
//   clk    in   clock, posedge
//   resetn in   asynchronous reset, active low
//   bus    slave modport of myfifo_write_arbiter_if (requesters + FIFO port)
//   grant  out  one-hot current owner, 0 when idle (registered)
//   busy   out  1 while a grant is held (registered)
// Build option:
//   MYFIFO_ARB_ROOM_CHECK_EN - when defined, a grant is only issued if the
//   FIFO has room for a full C_MAX_BURST burst; otherwise fifo_size is unused.
// ---------------------------------------------------------------------------
module myfifo_write_arbiter #(
  parameter int C_NUM_REQ    = 4,
  parameter int C_DATA_WIDTH = 64,
  parameter int C_MAX_BURST  = 8,
  parameter int C_FIFO_DEPTH = 10
) (
  input  logic                   clk,
  input  logic                   resetn,
  myfifo_write_arbiter_if.slave  bus,
  output logic [C_NUM_REQ-1:0]   grant,
  output logic                   busy
);
  localparam int OWN_W  = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(C_MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state;
  logic [OWN_W-1:0]    owner;
  logic [OWN_W-1:0]    last_owner;
  logic [BEAT_W-1:0]   beat_cnt;

  logic                pick_found;
  logic [OWN_W-1:0]    pick_idx;
  logic                room_ok;
  logic                commit;
  logic                release_burst;

  // FIFO room gate applied to new grants
`ifdef MYFIFO_ARB_ROOM_CHECK_EN
  always_comb begin
    room_ok = ((C_FIFO_DEPTH - int'(bus.fifo_size)) >= C_MAX_BURST);
  end
`else
  always_comb begin
    room_ok = 1'b1;
  end
`endif

  // Round-robin pick: first valid requester after last_owner, wrapping
  always_comb begin
    logic hit;
    int   idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    hit        = 1'b0;
    idx        = 0;
    for (int k = 1; k <= C_NUM_REQ; k++) begin
      idx        = (int'(last_owner) + k) % C_NUM_REQ;
      hit        = !pick_found && bus.req_valid[idx];
      pick_idx   = hit ? OWN_W'(idx) : pick_idx;
      pick_found = pick_found | hit;
    end
  end

  // Write-port mux and handshake steering toward the current owner
  always_comb begin
    bus.fifo_write_valid = 1'b0;
    bus.fifo_write_data  = '0;
    bus.req_ready        = '0;
    commit               = 1'b0;
    release_burst        = 1'b0;
    if (state == GRANT) begin
      bus.fifo_write_valid = bus.req_valid[owner];
      bus.fifo_write_data  = bus.req_data[owner*C_DATA_WIDTH +: C_DATA_WIDTH];
      bus.req_ready[owner] = bus.fifo_write_ready;
      commit               = bus.req_valid[owner] & bus.fifo_write_ready;
      // beat_cnt still holds the pre-commit count here, so the cap is hit
      // when this commit is beat number C_MAX_BURST
      release_burst        = commit &
                             (bus.req_last[owner] |
                              (beat_cnt == BEAT_W'(C_MAX_BURST - 1)));
    end else begin
      bus.fifo_write_valid = 1'b0;
      bus.req_ready        = '0;
    end
  end

  // Arbitration FSM with registered grant/busy and burst bookkeeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OWN_W'(C_NUM_REQ - 1);
      beat_cnt   <= '0;
      grant      <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found && room_ok) begin
            state    <= GRANT;
            owner    <= pick_idx;
            beat_cnt <= '0;
            grant    <= {{(C_NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            busy     <= 1'b1;
          end else begin
            grant    <= '0;
            busy     <= 1'b0;
          end
        end
        GRANT: begin
          if (release_burst) begin
            state      <= IDLE;
            last_owner <= owner;
            beat_cnt   <= '0;
            grant      <= '0;
            busy       <= 1'b0;
          end else if (commit) begin
            beat_cnt   <= beat_cnt + 1'b1;
          end else begin
            beat_cnt   <= beat_cnt;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
          grant    <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_myfifo_write_arbiter.sv
module tb_myfifo_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MB = 8;
  localparam int D  = 10;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  myfifo_write_arbiter_if #(.C_NUM_REQ(N), .C_DATA_WIDTH(W), .C_FIFO_DEPTH(D)) bus ();
  logic [N-1:0] grant;
  logic         busy;

  myfifo_write_arbiter #(
    .C_NUM_REQ(N), .C_DATA_WIDTH(W), .C_MAX_BURST(MB), .C_FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .grant(grant), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: who owns the port, beats in this burst, previous owner
  int m_owner;
  int m_beats;
  int m_last;

  // producers
  logic [W-1:0] cur_data [N];
  logic         cur_last [N];
  int           sent     [N];

  // scoreboards
  logic [W-1:0] exp_q [$];   // beats the model says were written
  logic [W-1:0] fifo_q [$];  // beats seen on the DUT write port
  int           dut_grants [$];
  int           dut_bursts [$];
  int           dut_len;
  logic [N-1:0] prev_grant;
  logic [N-1:0] obs_grant;

  int mode;
  int cyc;
  int fsize;

  task automatic drive_inputs();
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         rdy;
    v = '0; l = '0; rdy = 1'b1;
    case (mode)
      0: begin
        v = N'($urandom);
        for (int i = 0; i < N; i++) l[i] = cur_last[i];
        rdy   = ($urandom_range(0, 4) != 0);
        fsize = $urandom_range(0, D);
      end
      1: begin v = '1; l = '1; fsize = 0; end
      2: begin
        v[1] = (sent[1] < 20);
        l[1] = (sent[1] == 19);
        rdy  = !(cyc >= 3 && cyc < 8);
        fsize = 0;
      end
      3: begin v[0] = 1'b1; fsize = 0; end
      default: begin v[2] = 1'b1; l = '1; end
    endcase
    bus.req_valid        = v;
    bus.req_last         = l;
    bus.fifo_write_ready = rdy;
    bus.fifo_size        = 4'(fsize);
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = cur_data[i];
  endtask

  task automatic step();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic         room;
    logic         mcommit;
    int           g;
    drive_inputs();
    @(negedge clk);
    eg = '0; er = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      er[m_owner] = bus.fifo_write_ready;
    end
    check_val("grant", 64'(grant), 64'(eg));
    check_val("busy", 64'(busy), 64'(m_owner >= 0));
    check_val("req_ready", 64'(bus.req_ready), 64'(er));
    check_val("wvalid", 64'(bus.fifo_write_valid),
              64'((m_owner >= 0) && bus.req_valid[m_owner]));
    if (m_owner >= 0) check_val("wdata", bus.fifo_write_data, cur_data[m_owner]);
    obs_grant = grant;
    // observed-side bookkeeping
    if (bus.fifo_write_valid && bus.fifo_write_ready) begin
      fifo_q.push_back(bus.fifo_write_data);
      dut_len++;
    end
    if (grant != '0 && grant != prev_grant) dut_grants.push_back(int'(grant));
    if (grant == '0 && dut_len > 0) begin
      dut_bursts.push_back(dut_len);
      dut_len = 0;
    end
    prev_grant = grant;
    // model transition
    g = m_owner;
    mcommit = (g >= 0) && bus.req_valid[g] && bus.fifo_write_ready;
`ifdef MYFIFO_ARB_ROOM_CHECK_EN
    room = ((D - fsize) >= MB);
`else
    room = 1'b1;
`endif
    @(posedge clk);
    #1;
    if (g < 0) begin
      if (room) begin
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && bus.req_valid[(m_last + k) % N]) m_owner = (m_last + k) % N;
        end
        m_beats = 0;
      end
    end else if (mcommit) begin
      m_beats++;
      exp_q.push_back(cur_data[g]);
      if (bus.req_last[g] || m_beats == MB) begin
        m_owner = -1;
        m_last  = g;
        m_beats = 0;
      end
      sent[g]++;
      cur_data[g] = {$urandom, $urandom};
      cur_last[g] = ($urandom_range(0, 3) == 0);
    end
    cyc++;
  endtask

  task automatic model_clear();
    m_owner = -1; m_beats = 0; m_last = N - 1;
    prev_grant = '0; dut_len = 0;
  endtask

  task automatic do_reset();
    resetn        = 1'b0;
    bus.req_valid = '1;
    #1;
    check_val("rst_grant", 64'(grant), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_wvalid", 64'(bus.fifo_write_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  task automatic compare_fifo(input string tag);
    check_val({tag, "_count"}, 64'(fifo_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < fifo_q.size() && i < exp_q.size(); i++)
      check_val({tag, "_beat"}, fifo_q[i], exp_q[i]);
    fifo_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int exp_rot [5];
    int exp_cap [3];
    logic [W-1:0] hold_data;
    exp_rot = '{1, 2, 4, 8, 1};
    exp_cap = '{8, 8, 4};
    for (int i = 0; i < N; i++) begin
      cur_data[i] = {$urandom, $urandom};
      cur_last[i] = 1'b0;
      sent[i]     = 0;
    end
    mode = 1; cyc = 0; fsize = 0;
    bus.req_valid = '1; bus.req_last = '0; bus.req_data = '0;
    bus.fifo_write_ready = 1'b1; bus.fifo_size = '0;
    resetn = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // rotation, one beat per grant, first grant to requester 0
    mode = 1;
    dut_grants.delete();
    for (int c = 0; c < 11; c++) step();
    check_val("rot_count", 64'(dut_grants.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < dut_grants.size(); i++)
      check_val("rot_order", 64'(dut_grants[i]), 64'(exp_rot[i]));
    compare_fifo("rot_fifo");

    // burst cap with backpressure on requester 1
    do_reset();
    mode = 2; cyc = 0; sent[1] = 0;
    dut_bursts.delete();
    for (int c = 0; c < 80 && !(sent[1] >= 20 && m_owner < 0); c++) step();
    step();
    check_val("cap_nbursts", 64'(dut_bursts.size()), 64'd3);
    for (int i = 0; i < 3 && i < dut_bursts.size(); i++)
      check_val("cap_len", 64'(dut_bursts[i]), 64'(exp_cap[i]));
    compare_fifo("cap_fifo");

    // reset in the middle of a burst leaves exactly three beats written
    do_reset();
    mode = 3;
    for (int c = 0; c < 20 && fifo_q.size() < 3; c++) step();
    check_val("mid_busy", 64'(busy), 64'd1);
    hold_data = cur_data[0];
    do_reset();
    compare_fifo("mid_fifo");
    check_val("mid_data_kept", 64'(cur_data[0]), 64'(hold_data));

    // room gating
    mode = 4;
`ifdef MYFIFO_ARB_ROOM_CHECK_EN
    fsize = 3;
    for (int c = 0; c < 4; c++) step();
    check_val("room_nogrant", 64'(obs_grant), 64'd0);
    fsize = 2;
    step();
    step();
    check_val("room_grant", 64'(obs_grant), 64'h4);
`else
    fsize = 3;
    step();
    check_val("room_idle", 64'(obs_grant), 64'd0);
    step();
    check_val("room_grant", 64'(obs_grant), 64'h4);
`endif
    for (int c = 0; c < 4; c++) step();
    compare_fifo("room_fifo");

    // randomized traffic
    do_reset();
    mode = 0;
    for (int c = 0; c < 1500; c++) step();
    compare_fifo("rand_fifo");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
